fixed_int26_6_accumulator: RTL

FIXED_INT26_6_ACCUMULATOR -- requirements
Module: fixed_int26_6_accumulator

---
 rtl/fixed_int26_6_accumulator_pkg.sv | 20 ++
 rtl/fixed_int26_6_saturate.sv | 28 ++
 rtl/fixed_int26_6_accumulator.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fixed_int26_6_accumulator_pkg.sv
// Shared 26d6 fixed-point definitions: accumulator state encoding,
// saturation limits and the fraction width of the 26d6 format.
package fixed_int26_6_accumulator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_ACCUMULATE = 2'd1,
      ST_EMIT       = 2'd2
   } acc_state_e;

   localparam logic [31:0] SAT_MAX   = 32'h7FFF_FFFF;
   localparam logic [31:0] SAT_MIN   = 32'h8000_0000;
   localparam int unsigned FRAC_BITS = 6;

   // Build a 26d6 value from a signed 26-bit integer part (fraction zero).
   function automatic logic [31:0] fx_from_int(input logic [25:0] int_part);
      return {int_part, {FRAC_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/fixed_int26_6_saturate.sv
// Clamp a wide signed 26d6 accumulator to the signed 32-bit 26d6 range.
// The value fits when every bit from 31 upward equals the sign bit.
module fixed_int26_6_saturate
   import fixed_int26_6_accumulator_pkg::*;
#(
   parameter int COUNT_WIDTH = 16
) (
   input  logic [32+COUNT_WIDTH-1:0] acc_i,
   output logic [31:0]               sat_o
);

   localparam int IN_W = 32 + COUNT_WIDTH;

   logic [COUNT_WIDTH:0] upper_s;

   // Select the low word when it represents the value, otherwise the limit.
   always_comb begin
      upper_s = acc_i[IN_W-1:31];
      if ((upper_s == {(COUNT_WIDTH+1){1'b0}}) || (upper_s == {(COUNT_WIDTH+1){1'b1}})) begin
         sat_o = acc_i[31:0];
      end else if (acc_i[IN_W-1]) begin
         sat_o = SAT_MIN;
      end else begin
         sat_o = SAT_MAX;
      end
   end

endmodule

// File: rtl/fixed_int26_6_accumulator.sv
// Sums a commanded number of signed 26d6 products into a wide accumulator
// and emits the saturated 32-bit result through a one-entry output buffer.
module fixed_int26_6_accumulator
   import fixed_int26_6_accumulator_pkg::*;
#(
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   srst,
   input  logic                   goValid,
   output logic                   goStop,
   output logic                   doneValid,
   input  logic                   doneStop,
   input  logic                   lengthReady,
   input  logic [COUNT_WIDTH-1:0] lengthData,
   output logic                   lengthStop,
   input  logic                   productReady,
   input  logic [31:0]            productData,
   output logic                   productStop,
   output logic                   resultReady,
   output logic [31:0]            resultData,
   input  logic                   resultStop
);

   localparam int ACC_W = 32 + COUNT_WIDTH;
   localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

   acc_state_e             state_q,     state_d;
   logic [COUNT_WIDTH-1:0] count_q,     count_d;
   logic [ACC_W-1:0]       acc_q,       acc_d;
   logic                   buf_valid_q, buf_valid_d;
   logic [31:0]            buf_data_q,  buf_data_d;

   logic                   length_xfer_s;
   logic                   product_xfer_s;
   logic [ACC_W-1:0]       product_ext_s;
   logic [31:0]            sat_s;

   // Go/done handshake is a plain pass-through in both directions.
   assign doneValid = goValid;
   assign goStop    = doneStop;

   // Back-pressure depends on the state register only, never on a Stop input.
   assign lengthStop  = (state_q != ST_IDLE);
   assign productStop = (state_q != ST_ACCUMULATE);

   assign resultReady = buf_valid_q;
   assign resultData  = buf_data_q;

   assign length_xfer_s  = lengthReady  && !lengthStop;
   assign product_xfer_s = productReady && !productStop;
   assign product_ext_s  = {{COUNT_WIDTH{productData[31]}}, productData};

   fixed_int26_6_saturate #(
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_saturate (
      .acc_i (acc_q),
      .sat_o (sat_s)
   );

   // Next-state, accumulator and output-buffer computation.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      acc_d      = acc_q;
      buf_data_d = buf_data_q;

      if (buf_valid_q && !resultStop) begin
         buf_valid_d = 1'b0;
      end else begin
         buf_valid_d = buf_valid_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (length_xfer_s) begin
               acc_d   = {ACC_W{1'b0}};
               count_d = lengthData;
               if (lengthData != CNT_ZERO) begin
                  state_d = ST_ACCUMULATE;
               end else begin
                  state_d = ST_EMIT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCUMULATE: begin
            if (product_xfer_s) begin
               acc_d   = acc_q + product_ext_s;
               count_d = count_q - CNT_ONE;
               if (count_q == CNT_ONE) begin
                  state_d = ST_EMIT;
               end else begin
                  state_d = ST_ACCUMULATE;
               end
            end else begin
               state_d = ST_ACCUMULATE;
            end
         end
         ST_EMIT: begin
            // Only an empty buffer is loaded; a result drained this cycle
            // frees the buffer for the following cycle.
            if (!buf_valid_q) begin
               buf_valid_d = 1'b1;
               buf_data_d  = sat_s;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_EMIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (srst) begin
         state_q     <= ST_IDLE;
         count_q     <= CNT_ZERO;
         acc_q       <= {ACC_W{1'b0}};
         buf_valid_q <= 1'b0;
         buf_data_q  <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         acc_q       <= acc_d;
         buf_valid_q <= buf_valid_d;
         buf_data_q  <= buf_data_d;
      end
   end

endmodule
